// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage RV32I pipeline. Takes the EX/MEM register outputs,
// drives the data-memory request/ready handshake, resolves branch/jal/jalr
// redirects and produces the MEM/WB pipeline register.
//
// A two-state FSM (IDLE/WAIT) absorbs multi-cycle memory. While an access is
// outstanding, stall_out freezes IF/ID/EX. A wait counter bounds every access
// to MAX_WAIT cycles. After that the access is abandoned and reported as a
// fault.
//
// Parameters:
//   MAX_WAIT      cycles to wait for dmem_ready before aborting (1..255)
//   RESET_PC_TGT  PCtarget_out value while reset is asserted
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   Ctl_*_in, jal/jalr/Zero  EX/MEM control and jump flags
//   funct3_in, Rd_in         access width/sign and destination register
//   ALUresult_in, PCimm_in,
//   ReadData2_in, PC_in      EX/MEM data (address, branch target, store data, PC)
//   dmem_*                   data-memory request/ready interface
//   mem_data_out             forwarding value to EX (= ALUresult_in)
//   stall_out                freeze upstream stages
//   PCSrc_out, PCtarget_out  fetch redirect and its target
//   misalign_out, fault_out  registered one-cycle error pulses
//   Ctl_*_out, Rd_out,
//   ReadData_out,
//   ALUresult_out            MEM/WB pipeline register
//   stat_*_out               statistics counters (zero unless enabled)
//
// Optional feature: define MEM_STATS_EN to build the access/stall counters.
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned MAX_WAIT     = 15,
    parameter logic [31:0] RESET_PC_TGT = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Ctl_MemtoReg_in,
    input  logic        Ctl_RegWrite_in,
    input  logic        Ctl_MemRead_in,
    input  logic        Ctl_MemWrite_in,
    input  logic        Ctl_branch_in,
    input  logic        jal_in,
    input  logic        jalr_in,
    input  logic        Zero_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  Rd_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] PCimm_in,
    input  logic [31:0] ReadData2_in,
    input  logic [31:0] PC_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_data_out,
    output logic        stall_out,
    output logic        PCSrc_out,
    output logic [31:0] PCtarget_out,
    output logic        misalign_out,
    output logic        fault_out,
    output logic        Ctl_MemtoReg_out,
    output logic        Ctl_RegWrite_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUresult_out,
    output logic [31:0] stat_access_cnt_out,
    output logic [31:0] stat_stall_cnt_out
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;

    logic        memOp;
    logic        misalignedAddr;
    logic        accessNow;
    logic        lastWait;
    logic        timeoutNow;
    logic        misalignNow;
    logic        memFaultNow;
    logic        branchCond;
    logic [31:0] shiftedData;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] loadData;

    logic        memtoReg_q, regWrite_q, misalign_q, fault_q;
    logic [4:0]  rd_q;
    logic [31:0] readData_q, aluResult_q;

    // Decode the access. A word needs 4-byte alignment and a half 2-byte
    // alignment. A misaligned access never reaches the memory at all.
    always_comb begin
        memOp          = Ctl_MemRead_in | Ctl_MemWrite_in;
        misalignedAddr = ((funct3_in[1:0] == 2'b10) && (ALUresult_in[1:0] != 2'b00)) ||
                         ((funct3_in[1:0] == 2'b01) && ALUresult_in[0]);
        accessNow      = memOp & ~misalignedAddr;
    end

    // FSM state register, together with the wait counter that bounds how long
    // we sit in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // FSM next-state logic. A zero-wait memory finishes in IDLE without ever
    // entering WAIT. WAIT leaves on ready or when the wait budget runs out.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accessNow && !dmem_ready) begin
                    state_d   = ST_WAIT;
                    waitCnt_d = 8'd0;
                end
            end
            ST_WAIT: begin
                if (dmem_ready || (waitCnt_q == LAST_WAIT)) begin
                    state_d = ST_IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs. The request is combinational, so a same-cycle ready causes
    // no stall. On the final wait cycle the stall drops even without ready,
    // which lets the pipeline move on and the access retire as a fault.
    always_comb begin
        lastWait    = (state_q == ST_WAIT) && (waitCnt_q == LAST_WAIT);
        dmem_req    = !reset && ((state_q == ST_WAIT) || ((state_q == ST_IDLE) && accessNow));
        stall_out   = dmem_req && !dmem_ready && !lastWait;
        timeoutNow  = dmem_req && !dmem_ready && lastWait;
        misalignNow = memOp && misalignedAddr && !stall_out;
        memFaultNow = timeoutNow || misalignNow;
    end

    // Store lane steering. Sub-word store data is replicated across the bus so
    // that the byte enables alone select the lanes. Loads always read the
    // full word and then extract the lane locally.
    always_comb begin
        dmem_addr    = ALUresult_in;
        mem_data_out = ALUresult_in;
        dmem_we      = Ctl_MemWrite_in && !misalignedAddr;
        case (funct3_in[1:0])
            2'b00: begin
                dmem_wdata = {4{ReadData2_in[7:0]}};
                dmem_be    = 4'b0001 << ALUresult_in[1:0];
            end
            2'b01: begin
                dmem_wdata = {2{ReadData2_in[15:0]}};
                dmem_be    = 4'b0011 << ALUresult_in[1:0];
            end
            default: begin
                dmem_wdata = ReadData2_in;
                dmem_be    = 4'b1111;
            end
        endcase
        if (!Ctl_MemWrite_in) begin
            dmem_be = 4'b1111;
        end
    end

    // Load extraction. The byte lane comes from addr[1:0] and the half lane
    // from addr[1]. The upper funct3 bit selects zero- rather than
    // sign-extension.
    always_comb begin
        shiftedData = dmem_rdata >> {ALUresult_in[1:0], 3'b000};
        byteVal     = shiftedData[7:0];
        halfVal     = ALUresult_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_in)
            3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
            3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
            3'b100:  loadData = {24'h0, byteVal};
            3'b101:  loadData = {16'h0, halfVal};
            default: loadData = dmem_rdata;
        endcase
    end

    // Redirect resolution. beq takes on Zero. Every other branch type relies
    // on the ALU producing a non-zero result when its condition holds. No
    // redirect is issued while the stage is stalled.
    always_comb begin
        branchCond   = (funct3_in == 3'b000) ? Zero_in : !Zero_in;
        PCSrc_out    = !stall_out && ((Ctl_branch_in && branchCond) || jal_in || jalr_in);
        if (reset) begin
            PCtarget_out = RESET_PC_TGT;
        end else if (jalr_in) begin
            PCtarget_out = {ALUresult_in[31:1], 1'b0};
        end else begin
            PCtarget_out = PCimm_in;
        end
    end

    // MEM/WB pipeline register. A stall inserts a bubble by dropping the write
    // controls while the data fields hold. A load that faulted or was
    // misaligned retires without writing the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            memtoReg_q  <= 1'b0;
            regWrite_q  <= 1'b0;
            rd_q        <= 5'd0;
            readData_q  <= 32'h0;
            aluResult_q <= 32'h0;
            misalign_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            misalign_q <= misalignNow;
            fault_q    <= timeoutNow;
            if (stall_out) begin
                memtoReg_q <= 1'b0;
                regWrite_q <= 1'b0;
            end else begin
                memtoReg_q  <= Ctl_MemtoReg_in;
                regWrite_q  <= Ctl_RegWrite_in && !(Ctl_MemRead_in && memFaultNow);
                rd_q        <= Rd_in;
                readData_q  <= memFaultNow ? 32'h0 : loadData;
                aluResult_q <= (jal_in || jalr_in) ? (PC_in + 32'd4) : ALUresult_in;
            end
        end
    end

    assign Ctl_MemtoReg_out = memtoReg_q;
    assign Ctl_RegWrite_out = regWrite_q;
    assign Rd_out           = rd_q;
    assign ReadData_out     = readData_q;
    assign ALUresult_out    = aluResult_q;
    assign misalign_out     = misalign_q;
    assign fault_out        = fault_q;

`ifdef MEM_STATS_EN
    logic [31:0] statAccess_q;
    logic [31:0] statStall_q;

    // Statistics counters. An access counts once, on the cycle it leaves the
    // stage (ready or timeout), i.e. when the request is up and the stall has
    // dropped. Both counters wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            statAccess_q <= 32'h0;
            statStall_q  <= 32'h0;
        end else begin
            if (dmem_req && !stall_out) begin
                statAccess_q <= statAccess_q + 32'd1;
            end
            if (stall_out) begin
                statStall_q <= statStall_q + 32'd1;
            end
        end
    end

    assign stat_access_cnt_out = statAccess_q;
    assign stat_stall_cnt_out  = statStall_q;
`else
    assign stat_access_cnt_out = 32'h0;
    assign stat_stall_cnt_out  = 32'h0;
`endif

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Consumes the EX/MEM register outputs of the execution stage and drives the data-memory request/ready handshake.
- Resolves branch/jal/jalr redirects and produces the MEM/WB pipeline register.
- Multi-cycle memory is absorbed by a small FSM that raises stall_out to freeze IF/ID/EX. A wait-timeout counter bounds every access.

Parameters:
- MAX_WAIT, 15: cycles to wait for dmem_ready before the access is aborted as a fault; range 1..255.
- RESET_PC_TGT, 32'h0: value of PCtarget_out while in reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_branch_in  in  1 each  EX/MEM control.
- jal_in, jalr_in, Zero_in  in  1 each  jump flags and ALU zero from EX/MEM.
- funct3_in  in  3  instruction funct3, carried in EX/MEM.
- Rd_in  in  5  destination register.
- ALUresult_in, PCimm_in, ReadData2_in, PC_in  in  32 each  EX/MEM data.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  byte address, equal to ALUresult_in.
- dmem_wdata  out  32  store data lane-replicated.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  access complete this cycle.
- dmem_rdata  in  32  aligned read word.
- mem_data_out  out  32  combinational forwarding value to EX; = ALUresult_in.
- stall_out  out  1  freeze upstream stages.
- PCSrc_out  out  1  redirect fetch; also the IF/ID/EX flush.
- PCtarget_out  out  32  redirect address.
- misalign_out  out  1  one-cycle pulse.
- fault_out  out  1  one-cycle pulse.
- Ctl_MemtoReg_out, Ctl_RegWrite_out  out  1 each  MEM/WB control.
- Rd_out  out  5  MEM/WB destination.
- ReadData_out, ALUresult_out  out  32 each  MEM/WB data.

Behaviour:
- Definitions:
  - access = (MemRead_in | MemWrite_in) & !misaligned.
  - misaligned: funct3[1:0]==2'b10 with addr[1:0]!=0, or funct3[1:0]==2'b01 with addr[0]!=0.
- FSM states: IDLE, WAIT.
  - IDLE: if access & !dmem_ready, go to WAIT and clear wait_cnt.
  - WAIT: if dmem_ready, or wait_cnt==MAX_WAIT-1, go to IDLE; otherwise wait_cnt+1.
- dmem_req = !reset & (state==WAIT | (state==IDLE & access)). Combinational, so a zero-wait memory completes in the same cycle with no stall.
- stall_out = dmem_req & !dmem_ready & !(state==WAIT & wait_cnt==MAX_WAIT-1).
- Store lanes:
  - sb: be=0001 << addr[1:0], wdata = byte replicated x4.
  - sh: be=0011 << addr[1:0], wdata = half replicated x2.
  - sw: be=1111.
  - Loads drive be=1111 and we=0.
- Load extract by funct3: lb/lh sign-extend, lbu/lhu zero-extend, lw as-is. Lane is selected by addr[1:0].
- Branch decision (evaluated only when !stall_out):
  - beq: Zero_in.
  - bne: !Zero_in.
  - blt/bge/bltu/bgeu: !Zero_in (ALU outputs 1 when the condition holds).
  - PCSrc_out = (branch & cond) | jal_in | jalr_in.
- PCtarget_out = jalr_in ? (ALUresult_in & ~1) : PCimm_in. PCSrc_out and PCtarget_out are combinational.
- MEM/WB register, posedge clk:
  - If reset: all outputs 0.
  - Else if stall_out: bubble, with Ctl_RegWrite_out=0 and Ctl_MemtoReg_out=0. Other fields hold.
  - Else: capture. ALUresult_out = (jal|jalr) ? PC_in+4 : ALUresult_in. ReadData_out = extracted load data, or 0 on fault/misalign.
- Misaligned access:
  - No dmem_req; the store is suppressed.
  - Load gets Ctl_RegWrite_out=0.
  - misalign_out pulses for 1 cycle, registered.
- Timeout:
  - The access ends on the cycle wait_cnt reaches MAX_WAIT-1; stall drops that cycle.
  - fault_out pulses; load gets RegWrite_out=0.
- Reset mid-WAIT: dmem_req is gated low in the reset cycle; state=IDLE, wait_cnt=0, pulses cleared next edge.
- dmem_ready while state==IDLE & !access is ignored.

Optional Feature:
- Macro MEM_STATS_EN.
- When defined:
  - Adds 32-bit counters stat_access_cnt (+1 per completed access) and stat_stall_cnt (+1 per cycle stall_out=1).
  - Both are cleared by reset, wrap at 2^32, and drive output ports stat_access_cnt_out and stat_stall_cnt_out.
- When undefined: no counters are built and both ports are tied to 32'h0.

Test Plan:
- lw at addr 0x10, dmem_ready=1 same cycle, rdata=0xDEADBEEF -> no stall; next cycle ReadData_out=0xDEADBEEF, Ctl_RegWrite_out=1.
- lb at addr 0x13, rdata=0x80FF_0000, ready after 3 cycles -> stall_out high exactly 3 cycles with RegWrite_out=0 bubbles; then ReadData_out=0xFFFFFF80.
- sh of 0x1234ABCD at addr 0x22 -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
- lw at addr 0x11 -> dmem_req=0, misalign_out=1 one cycle, RegWrite_out=0; lw with ready never asserted, MAX_WAIT=15 -> 15 stall-cycles, fault_out=1.
- bne with Zero_in=0, PCimm_in=0x40 -> PCSrc_out=1, target 0x40. jalr with ALUresult_in=0x103, PC_in=0x20 -> target 0x102, ALUresult_out=0x24.
- reset asserted during WAIT -> dmem_req=0 that cycle, all outputs 0 next edge. With MEM_STATS_EN, counters read 0 after reset.
